lsu_controller: RTL

Multi-cycle load/store sequencer between the core's memory-stage control signals (read/write enable, mem_size_t, address, store data) and a word-wide memory port with a valid/ready request and valid response handshake. It stalls the core while a transaction is outstanding. It steers byte/half lanes, generates write strobes, sign/zero-extends load data and flags misaligned accesses. It sits between the execute stage and the data memory, replacing the single-cycle direct memory hookup.

---
 rtl/enums_pkg.sv | 25 ++
 rtl/lsu_data_align.sv | 58 +++++
 rtl/lsu_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/enums_pkg.sv
// rtl/enums_pkg.sv - shared enums for the load/store path
package enums_pkg;

    typedef enum logic [2:0] {
        MEM_BYTE  = 3'd0,
        MEM_BYTEU = 3'd1,
        MEM_HALF  = 3'd2,
        MEM_HALFU = 3'd3,
        MEM_WORD  = 3'd4
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'd0,
        FAULT_MISALIGNED = 2'd1,
        FAULT_TIMEOUT    = 2'd2
    } lsu_fault_t;

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - lane steering, strobes, load extension and alignment check
module lsu_data_align
    import enums_pkg::*;
(
    input  mem_size_t   size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    input  mem_size_t   chk_size_i,
    input  logic [1:0]  chk_off_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata_i[{off_i, 3'b000} +: 8];
    assign rd_half = rdata_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = 32'h0;
        case (size_i)
            MEM_BYTE, MEM_BYTEU: begin
                wstrb_o = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = (size_i == MEM_BYTE) ? {{24{rd_byte[7]}}, rd_byte}
                                               : {24'h0, rd_byte};
            end
            MEM_HALF, MEM_HALFU: begin
                wstrb_o = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = (size_i == MEM_HALF) ? {{16{rd_half[15]}}, rd_half}
                                               : {16'h0, rd_half};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

    // Checked on the incoming request so a fault never reaches the bus
    always_comb begin
        misaligned_o = 1'b0;
        case (chk_size_i)
            MEM_HALF, MEM_HALFU: misaligned_o = chk_off_i[0];
            MEM_WORD:            misaligned_o = |chk_off_i;
            default:             misaligned_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// rtl/lsu_controller.sv - load/store sequencer FSM; LSU_TIMEOUT_EN adds a bus timeout fault
module lsu_controller
    import enums_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  mem_size_t   req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output lsu_fault_t  resp_fault_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rdata_i
);

    lsu_state_t  state_q, state_d;
    logic        write_q, write_d;
    mem_size_t   size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    lsu_fault_t  fault_q, fault_d;

    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misaligned;

    lsu_data_align u_align (
        .size_i       (size_q),
        .off_i        (addr_q[1:0]),
        .wdata_i      (wdata_q),
        .rdata_i      (mem_rdata_i),
        .chk_size_i   (req_size_i),
        .chk_off_i    (req_addr_i[1:0]),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_misaligned)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= MEM_BYTE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    write_d = req_write_i;
                    size_d  = req_size_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    rdata_d = 32'h0;
                    fault_d = al_misaligned ? FAULT_MISALIGNED : FAULT_NONE;
                    state_d = al_misaligned ? DONE : REQ;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                if (mem_req_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid_i) begin
                    rdata_d = write_q ? 32'h0 : al_rdata;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef LSU_TIMEOUT_EN
        // Timeout overrides a same-cycle accept or response
        if (state_q == REQ || state_q == WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                state_d = DONE;
                fault_d = FAULT_TIMEOUT;
                rdata_d = 32'h0;
            end
        end
`endif
    end

    logic in_req;
    logic in_done;
    assign in_req  = (state_q == REQ);
    assign in_done = (state_q == DONE);

    assign stall_o         = req_valid_i && !in_done;
    assign resp_valid_o    = in_done;
    assign resp_rdata_o    = in_done ? rdata_q : 32'h0;
    assign resp_fault_o    = in_done ? fault_q : FAULT_NONE;
    assign mem_req_valid_o = in_req;
    assign mem_we_o        = in_req && write_q;
    assign mem_addr_o      = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wstrb_o     = (in_req && write_q) ? al_wstrb : 4'b0000;
    assign mem_wdata_o     = (in_req && write_q) ? al_wdata : 32'h0;

endmodule
